// File: rtl/param_data_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and helpers for param_data_memory: clear-engine
//            state encoding, read-mode constants and a safe clog2.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Clear engine states, explicitly one bit wide
  typedef enum logic [0:0] {
    MEM_CLEAR = 1'b0,
    MEM_READY = 1'b1
  } mem_state_t;

  // Read-mode selectors for the READ_REG parameter
  localparam int RD_ASYNC = 0;
  localparam int RD_REG   = 1;

  // Address width for a given depth; never less than one bit
  function automatic int clog2_safe(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/param_data_memory_if.sv
`default_nettype none
// ============================================================================
// Module   : param_data_memory_if
// Purpose  : Access bus of param_data_memory: clear request, one write port,
//            two read ports and the status flags.
// Revision : 1.0 - initial release
// ============================================================================
interface param_data_memory_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              clear_req;
  logic              write_en;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] read_data_a;
  logic [DATA_W-1:0] read_data_b;
  logic              busy;
  logic              addr_err;

  // Datapath / load-store side
  modport master (
    output clear_req, write_en, waddr, write_data, raddr_a, raddr_b,
    input  read_data_a, read_data_b, busy, addr_err
  );

  // Memory side
  modport slave (
    input  clear_req, write_en, waddr, write_data, raddr_a, raddr_b,
    output read_data_a, read_data_b, busy, addr_err
  );
endinterface
`default_nettype wire

// File: rtl/param_data_memory_clear_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mem_clear_fsm
// Purpose  : Clear engine. Walks a pointer over every word after reset or a
//            clear request, issuing zero writes, then reports ready.
// Revision : 1.0 - initial release
// ============================================================================
module mem_clear_fsm
  import mem_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = clog2_safe(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_clear_req,
  output logic                   o_busy,
  output logic                   o_ready,
  output logic                   o_clr_we,
  output logic [ADDR_W-1:0]      o_clr_addr
);

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

  mem_state_t        r_state;
  mem_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;

  // State and pointer register; reset parks the engine at word 0 in CLEAR
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MEM_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next state: sweep the array once, then wait for a clear request
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      MEM_CLEAR: begin
        if (r_ptr == c_last) begin
          w_state_nxt = MEM_READY;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      MEM_READY: begin
        if (i_clear_req) begin
          w_state_nxt = MEM_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = MEM_CLEAR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Outputs: zero-write strobe is held off while reset is asserted
  always_comb begin
    o_busy     = (r_state == MEM_CLEAR);
    o_ready    = (r_state == MEM_READY);
    o_clr_we   = (r_state == MEM_CLEAR) && !rst;
    o_clr_addr = r_ptr;
  end

endmodule
`default_nettype wire

// File: rtl/param_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : param_data_memory
// Purpose  : Parametrised data memory with one synchronous write port, two
//            read ports (async or registered), a built-in clear engine and an
//            out-of-range access flag.
// Revision : 1.0 - initial release
// ============================================================================
module param_data_memory
  import mem_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = clog2_safe(DEPTH),
  parameter int READ_REG = RD_ASYNC
) (
  input wire logic            clk,
  input wire logic            rst,
  param_data_memory_if.slave  bus
);

  // One extra bit so the range compare stays meaningful at power-of-two depths
  localparam logic [ADDR_W:0] c_depth = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_ready;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_in_range;
  logic              w_rd_in_range_a;
  logic              w_rd_in_range_b;
  logic              w_wr_ok;
  logic              w_rd_ok_a;
  logic              w_rd_ok_b;
  logic              w_access_err;
  logic              r_addr_err;

  mem_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk         (clk),
    .rst         (rst),
    .i_clear_req (bus.clear_req),
    .o_busy      (w_busy),
    .o_ready     (w_ready),
    .o_clr_we    (w_clr_we),
    .o_clr_addr  (w_clr_addr)
  );

  assign w_wr_in_range   = ({1'b0, bus.waddr}   < c_depth);
  assign w_rd_in_range_a = ({1'b0, bus.raddr_a} < c_depth);
  assign w_rd_in_range_b = ({1'b0, bus.raddr_b} < c_depth);

  assign w_wr_ok   = w_ready && bus.write_en && w_wr_in_range;
  assign w_rd_ok_a = w_ready && w_rd_in_range_a;
  assign w_rd_ok_b = w_ready && w_rd_in_range_b;

  // Only enabled writes count; reads are always live so any bad read address counts
  assign w_access_err = (bus.write_en && !w_wr_in_range) ||
                        !w_rd_in_range_a || !w_rd_in_range_b;

  // Single array write port: the clear engine owns it while busy
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_ok) begin
      r_mem[bus.waddr] <= bus.write_data;
    end
  end

  // Out-of-range flag, one cycle after the offending access, suppressed while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_ready && w_access_err;
    end
  end

  assign bus.addr_err = r_addr_err && !w_busy;
  assign bus.busy     = w_busy;

  generate
    if (READ_REG == RD_REG) begin : g_rd_reg
      logic [DATA_W-1:0] r_rd_a;
      logic [DATA_W-1:0] r_rd_b;
      logic              w_fwd_a;
      logic              w_fwd_b;

      // Write-first: a same-address write in this cycle bypasses the array
      assign w_fwd_a = w_wr_ok && (bus.waddr == bus.raddr_a);
      assign w_fwd_b = w_wr_ok && (bus.waddr == bus.raddr_b);

      // Registered read ports, zero when busy or out of range
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd_a <= '0;
          r_rd_b <= '0;
        end else begin
          r_rd_a <= !w_rd_ok_a ? '0 : (w_fwd_a ? bus.write_data : r_mem[bus.raddr_a]);
          r_rd_b <= !w_rd_ok_b ? '0 : (w_fwd_b ? bus.write_data : r_mem[bus.raddr_b]);
        end
      end

      // Hold outputs at zero for the whole clear, including its first cycle
      assign bus.read_data_a = w_busy ? '0 : r_rd_a;
      assign bus.read_data_b = w_busy ? '0 : r_rd_b;
    end else begin : g_rd_async
      assign bus.read_data_a = w_rd_ok_a ? r_mem[bus.raddr_a] : '0;
      assign bus.read_data_b = w_rd_ok_b ? r_mem[bus.raddr_b] : '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_param_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_data_memory
// Purpose  : Directed self-checking bench for param_data_memory across three
//            builds: 16 words async read, 16 words registered read, 12 words
//            async read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_data_memory;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  int   n0;
  int   n1;
  int   n2;

  param_data_memory_if #(.DATA_W(8), .ADDR_W(4)) if0 ();
  param_data_memory_if #(.DATA_W(8), .ADDR_W(4)) if1 ();
  param_data_memory_if #(.DATA_W(8), .ADDR_W(4)) if2 ();

  param_data_memory #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .READ_REG(0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (if0.slave)
  );
  param_data_memory #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .READ_REG(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );
  param_data_memory #(.DATA_W(8), .DEPTH(12), .ADDR_W(4), .READ_REG(0)) u_dut2 (
    .clk (clk), .rst (rst), .bus (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles each DUT reports busy, bounded so a stuck engine cannot hang
  task automatic count_busy(output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int k = 0; k < 100; k++) begin
      if (!(if0.busy || if1.busy || if2.busy)) break;
      if (if0.busy) c0++;
      if (if1.busy) c1++;
      if (if2.busy) c2++;
      tick();
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    {if0.clear_req, if0.write_en, if0.waddr, if0.write_data, if0.raddr_a, if0.raddr_b} = '0;
    {if1.clear_req, if1.write_en, if1.waddr, if1.write_data, if1.raddr_a, if1.raddr_b} = '0;
    {if2.clear_req, if2.write_en, if2.waddr, if2.write_data, if2.raddr_a, if2.raddr_b} = '0;

    // Reset held three cycles, then the power-on clear
    rst = 1'b1;
    tick(); tick(); tick();
    check("rst_busy0", {31'd0, if0.busy}, 32'd1);
    check("rst_err0", {31'd0, if0.addr_err}, 32'd0);
    check("rst_rd1", {24'd0, if1.read_data_a}, 32'd0);
    rst = 1'b0;
    count_busy(n0, n1, n2);
    check("clr_len16_async", n0, 32'd16);
    check("clr_len16_reg", n1, 32'd16);
    check("clr_len12", n2, 32'd12);
    for (int i = 0; i < 16; i++) begin
      if0.raddr_a = 4'(i);
      #1;
      check($sformatf("clr_rd0_%0d", i), {24'd0, if0.read_data_a}, 32'd0);
    end
    if0.raddr_a = 4'd0;

    // Registered read: write then read one cycle later
    if1.write_en = 1'b1; if1.waddr = 4'd3; if1.write_data = 8'hA5;
    tick();
    if1.write_en = 1'b0; if1.raddr_a = 4'd3;
    tick();
    check("reg_rd_a5", {24'd0, if1.read_data_a}, 32'h0000_00A5);
    if1.raddr_a = 4'd4;
    tick();
    check("reg_rd_4", {24'd0, if1.read_data_a}, 32'd0);

    // Registered collision: write-first on both ports
    if1.write_en = 1'b1; if1.waddr = 4'd7; if1.write_data = 8'h3C;
    if1.raddr_a = 4'd7; if1.raddr_b = 4'd7;
    tick();
    if1.write_en = 1'b0;
    check("coll_a", {24'd0, if1.read_data_a}, 32'h0000_003C);
    check("coll_b", {24'd0, if1.read_data_b}, 32'h0000_003C);

    // Async collision: old data before the edge, new data after
    if0.write_en = 1'b1; if0.waddr = 4'd7; if0.write_data = 8'h5A;
    if0.raddr_a = 4'd7; if0.raddr_b = 4'd7;
    #1;
    check("acoll_old", {24'd0, if0.read_data_a}, 32'd0);
    tick();
    if0.write_en = 1'b0;
    check("acoll_new_a", {24'd0, if0.read_data_a}, 32'h0000_005A);
    check("acoll_new_b", {24'd0, if0.read_data_b}, 32'h0000_005A);

    // Busy lockout: clear request, blocked write at cycle 5
    if0.clear_req = 1'b1;
    tick();
    if0.clear_req = 1'b0;
    check("lock_busy", {31'd0, if0.busy}, 32'd1);
    check("lock_rd0", {24'd0, if0.read_data_a}, 32'd0);
    if0.clear_req = 1'b1;
    tick();
    if0.clear_req = 1'b0;
    tick(); tick(); tick();
    if0.write_en = 1'b1; if0.waddr = 4'd2; if0.write_data = 8'hFF; if0.raddr_a = 4'd2;
    #1;
    check("lock_rd_busy", {24'd0, if0.read_data_a}, 32'd0);
    tick();
    if0.write_en = 1'b0;
    count_busy(n0, n1, n2);
    check("lock_remain", n0, 32'd11);
    check("lock_addr2", {24'd0, if0.read_data_a}, 32'd0);
    if0.raddr_a = 4'd7;
    #1;
    check("lock_addr7", {24'd0, if0.read_data_a}, 32'd0);

    // Out of range on the 12-word build
    if2.write_en = 1'b1; if2.waddr = 4'd1; if2.write_data = 8'h22;
    tick();
    check("oor_err_ok", {31'd0, if2.addr_err}, 32'd0);
    if2.waddr = 4'd13; if2.write_data = 8'h11;
    tick();
    if2.write_en = 1'b0; if2.waddr = 4'd0;
    check("oor_wr_err", {31'd0, if2.addr_err}, 32'd1);
    tick();
    check("oor_wr_err_gone", {31'd0, if2.addr_err}, 32'd0);
    if2.raddr_a = 4'd14;
    #1;
    check("oor_rd14", {24'd0, if2.read_data_a}, 32'd0);
    tick();
    check("oor_rd_err", {31'd0, if2.addr_err}, 32'd1);
    if2.raddr_a = 4'd1;
    #1;
    check("oor_keep1", {24'd0, if2.read_data_a}, 32'h0000_0022);
    tick();
    check("oor_rd_err_gone", {31'd0, if2.addr_err}, 32'd0);
    if2.raddr_a = 4'd11;
    #1;
    check("oor_last_word", {24'd0, if2.read_data_a}, 32'd0);

    // Reset in the middle of a clear restarts it from word 0
    if0.clear_req = 1'b1;
    tick();
    if0.clear_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("mid_busy", {31'd0, if0.busy}, 32'd1);
    rst = 1'b1;
    if2.raddr_a = 4'd14;
    tick(); tick();
    check("mid_rst_rd1", {24'd0, if1.read_data_a}, 32'd0);
    rst = 1'b0;
    tick();
    check("mid_err_busy", {31'd0, if2.addr_err}, 32'd0);
    count_busy(n0, n1, n2);
    check("mid_len16", n0 + 1, 32'd16);
    check("mid_len12", n2 + 1, 32'd12);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_data_memory.md
Name: param_data_memory

Overview:
Parametrised successor to the 16x8 data memory. It has width, depth and read latency set by parameters, one synchronous write port and two independent read ports. A built-in clear engine zeroes the whole array after reset or on request, and reports progress on a busy flag. It sits between the processor datapath and its load/store unit, and is the data store for wider perceptron/processor builds.

Parameters:
DATA_W, 8, word width in bits
DEPTH, 16, number of words (any value >= 2, need not be a power of two)
ADDR_W, $clog2(DEPTH), address width
READ_REG, 0, 0 = asynchronous read; 1 = registered read, 1-cycle latency

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
clear_req  in  1  single-cycle pulse requesting a full-array clear
write_en  in  1  write enable
waddr  in  ADDR_W  write address
write_data  in  DATA_W  write data
raddr_a  in  ADDR_W  read port A address
raddr_b  in  ADDR_W  read port B address
read_data_a  out  DATA_W  read port A data
read_data_b  out  DATA_W  read port B data
busy  out  1  clear in progress; accesses are ignored
addr_err  out  1  registered one-cycle flag: the previous cycle had an out-of-range access

Behaviour:
- Reset: rst sampled high on a clock edge produces the following.
  - State goes to CLEAR, clear pointer to 0, busy=1, addr_err=0.
  - Registered read outputs go to 0.
  - While rst is held, the engine stays at pointer 0.
- State machine has two states, CLEAR and READY.
  - CLEAR: each cycle with rst low, writes 0 to mem[ptr], then ptr++.
  - When ptr==DEPTH-1 is written, the next state is READY and busy drops on that same edge.
  - A clear therefore takes exactly DEPTH cycles after rst deasserts.
  - READY: clear_req=1 moves to CLEAR with ptr=0 and busy=1 on the next edge.
  - clear_req while already in CLEAR is ignored; the clear is not restarted.
- Reset mid-clear: ptr returns to 0 and the clear restarts once rst deasserts.
- Write, READY only: on a rising edge with write_en=1 and waddr<DEPTH, mem[waddr] <= write_data.
  - While busy=1, write_en is ignored.
- Read, READY only:
  - READ_REG=0: read_data_x = mem[raddr_x] combinationally.
  - READ_REG=1: read_data_x is registered from mem[raddr_x] at the edge, so data is visible the cycle after the address.
  - While busy=1, read_data_x = 0 in both modes.
- Read/write collision, same cycle and same address:
  - READ_REG=1: write-first; the registered output takes write_data.
  - READ_REG=0: the output shows old data until the edge, then new data.
  - Ports A and B may address the same word; both return identical data.
- Out of range, when DEPTH is not a power of two:
  - A write to address >= DEPTH is dropped.
  - A read from address >= DEPTH returns 0.
  - addr_err=1 for exactly one cycle after any such access. Only write accesses with write_en=1 count; any read access counts.
  - addr_err is forced to 0 while busy=1.
- No initialization file. Array contents are defined only by the clear engine; simulation with X before the first clear is legal.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum (MEM_CLEAR, MEM_READY);
  - a function clog2_safe returning a minimum of 1;
  - constant RD_ASYNC=0 / RD_REG=1.
- Sub-module mem_clear_fsm holds the state register, the pointer and the busy output. It emits clr_we, clr_addr and ready.
- The top level muxes the clear engine and the user write port into a single write port on the array.

Test Plan:
- Reset clear, DEPTH=16, READ_REG=0: assert rst 3 cycles then release. Required: busy=1 for exactly 16 cycles; afterwards raddr_a=0..15 all read 0x00.
- Write then read, READ_REG=1: write 0xA5 @ addr 3, then set raddr_a=3 the following cycle. Required: read_data_a=0xA5 one cycle later; a read of addr 4 gives 0x00.
- Collision, READ_REG=1: same cycle, write_en=1, waddr=7, data=0x3C, raddr_a=raddr_b=7. Required: both outputs show 0x3C after the edge.
- Busy lockout: clear_req pulse, then write 0xFF @ addr 2 at cycle 5 of the clear. Required: write dropped, so addr 2 reads 0x00 after busy falls; read_data=0 during busy.
- Out of range, DEPTH=12: write 0x11 @ addr 13. Required: addr_err=1 for one cycle; the array is unchanged; a read of addr 14 returns 0x00 with addr_err pulsing.
- Reset mid-clear: assert rst at cycle 8 of a clear. Required: after release, busy stays high for a full 16 further cycles.
